// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: registers the instruction, formats load data and drives write/retire strobes.
// Optional retire counter on instret_o is built only when WB_RETIRE_CNT_EN is defined.
module writeback_stage #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 32,
   parameter int CNTWIDTH = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_i,
   input  logic [AWIDTH-1:0]   pc_i,
   input  logic [DWIDTH-1:0]   alu_res_i,
   input  logic [DWIDTH-1:0]   memory_data_i,
   input  logic [1:0]          wbsel_i,
   input  logic [2:0]          funct3_i,
   input  logic [4:0]          rd_i,
   input  logic                regwen_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic                valid_o,
   output logic [AWIDTH-1:0]   pc_o,
   output logic [4:0]          rd_o,
   output logic [DWIDTH-1:0]   writeback_data_o,
   output logic                regwen_o,
   output logic                retire_o,
   output logic [CNTWIDTH-1:0] instret_o
);

   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DWIDTH-1:0] ld_data;
   logic [DWIDTH-1:0] wd_next;
   logic [AWIDTH-1:0] pc_plus4;

   logic              valid_q;
   logic              fresh_q;
   logic              regwen_q;
   logic [AWIDTH-1:0] pc_q;
   logic [4:0]        rd_q;
   logic [DWIDTH-1:0] wd_q;

   always_comb begin
      ld_byte = memory_data_i[7:0];
      case (alu_res_i[1:0])
         2'd1:    ld_byte = memory_data_i[15:8];
         2'd2:    ld_byte = memory_data_i[23:16];
         2'd3:    ld_byte = memory_data_i[31:24];
         default: ld_byte = memory_data_i[7:0];
      endcase
      ld_half = alu_res_i[1] ? memory_data_i[31:16] : memory_data_i[15:0];
   end

   always_comb begin
      ld_data = memory_data_i;
      case (funct3_i)
         3'b000:  ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
         3'b001:  ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
         3'b101:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
         default: ld_data = memory_data_i;
      endcase
   end

   // Write data is resolved before the stage register so outputs come straight from flops.
   always_comb begin
      pc_plus4 = pc_i + AWIDTH'(4);
      wd_next  = alu_res_i;
      case (wbsel_i)
         2'b01:   wd_next = ld_data;
         2'b10:   wd_next = DWIDTH'(pc_plus4);
         default: wd_next = alu_res_i;
      endcase
   end

   // fresh_q marks the first cycle an instruction sits here, so a held instruction acts only once.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         fresh_q  <= 1'b0;
         regwen_q <= 1'b0;
         pc_q     <= '0;
         rd_q     <= '0;
         wd_q     <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         fresh_q <= 1'b0;
      end else if (stall_i) begin
         fresh_q <= 1'b0;
      end else begin
         valid_q  <= valid_i;
         fresh_q  <= 1'b1;
         regwen_q <= regwen_i;
         pc_q     <= pc_i;
         rd_q     <= rd_i;
         wd_q     <= wd_next;
      end
   end

   assign valid_o          = valid_q;
   assign pc_o             = pc_q;
   assign rd_o             = rd_q;
   assign writeback_data_o = wd_q;
   assign retire_o         = valid_q & fresh_q;
   assign regwen_o         = valid_q & fresh_q & regwen_q & (rd_q != 5'd0);

`ifdef WB_RETIRE_CNT_EN
   logic [CNTWIDTH-1:0] instret_q;

   always_ff @(posedge clk) begin
      if (reset)
         instret_q <= '0;
      else if (retire_o)
         instret_q <= instret_q + CNTWIDTH'(1);
   end

   assign instret_o = instret_q;
`else
   assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected outputs, a negedge monitor checks them.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] pc_i;
   logic [31:0] alu_res_i;
   logic [31:0] memory_data_i;
   logic [1:0]  wbsel_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_i;
   logic        regwen_i;
   logic        stall_i;
   logic        flush_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [4:0]  rd_o;
   logic [31:0] writeback_data_o;
   logic        regwen_o;
   logic        retire_o;
   logic [63:0] instret_o;

   writeback_stage dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .alu_res_i(alu_res_i),
      .memory_data_i(memory_data_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i), .rd_i(rd_i),
      .regwen_i(regwen_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
      .pc_o(pc_o), .rd_o(rd_o), .writeback_data_o(writeback_data_o), .regwen_o(regwen_o),
      .retire_o(retire_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        rw;
      logic        rt;
      logic [63:0] ic;
      logic        known;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // reference state of the stage as seen from outside
   logic        m_v, m_fresh, m_rw, m_known;
   logic [31:0] m_pc, m_wd;
   logic [4:0]  m_rd;
   logic [63:0] m_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.cyc != cyc) chk("sched", 64'(cyc), 64'(e.cyc));
         chk("valid_o", 64'(valid_o), 64'(e.v));
         chk("retire_o", 64'(retire_o), 64'(e.rt));
         chk("regwen_o", 64'(regwen_o), 64'(e.rw));
         chk("instret_o", instret_o, e.ic);
         if (e.known) begin
            chk("pc_o", 64'(pc_o), 64'(e.pc));
            chk("rd_o", 64'(rd_o), 64'(e.rd));
            chk("wdata", 64'(writeback_data_o), 64'(e.wd));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp();
      exp_t e;
      e.cyc   = cyc + 1;
      e.v     = m_v;
      e.pc    = m_pc;
      e.rd    = m_rd;
      e.wd    = m_wd;
      e.rt    = m_v & m_fresh;
      e.rw    = m_v & m_fresh & m_rw & (m_rd != 5'd0);
      e.ic    = m_cnt;
      e.known = m_known;
`ifdef WB_RETIRE_CNT_EN
      m_cnt = m_cnt + 64'(e.rt);
`endif
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [1:0] ws, input logic [2:0] f3,
                        input logic [4:0] rd, input logic rw, input logic st, input logic fl,
                        input logic [31:0] exp_wd);
      valid_i = v; pc_i = pc; alu_res_i = alu; memory_data_i = mem; wbsel_i = ws;
      funct3_i = f3; rd_i = rd; regwen_i = rw; stall_i = st; flush_i = fl; reset = 1'b0;
      if (fl) begin
         m_v = 1'b0; m_fresh = 1'b0; m_known = 1'b0;
      end else if (st) begin
         m_fresh = 1'b0;
      end else begin
         m_v = v; m_fresh = 1'b1; m_pc = pc; m_rd = rd; m_wd = exp_wd; m_rw = rw; m_known = 1'b1;
      end
      push_exp();
      step();
   endtask

   task automatic do_reset();
      valid_i = 1'b1; pc_i = 32'h55; alu_res_i = 32'h77; memory_data_i = 32'h99;
      wbsel_i = 2'b00; funct3_i = 3'b010; rd_i = 5'd4; regwen_i = 1'b1;
      stall_i = 1'b1; flush_i = 1'b0; reset = 1'b1;
      m_v = 1'b0; m_fresh = 1'b0; m_rw = 1'b0; m_known = 1'b1;
      m_pc = '0; m_rd = '0; m_wd = '0; m_cnt = '0;
      push_exp();
      step();
   endtask

   initial begin
      do_reset();
      do_reset();
      // load formatting
      issue(1, 32'h0000_1000, 32'h1000_0003, 32'h80AA_BBCC, 2'b01, 3'b000, 5'd5, 1, 0, 0, 32'hFFFF_FF80);
      issue(1, 32'h0000_1004, 32'h1000_0002, 32'h8001_1234, 2'b01, 3'b101, 5'd6, 1, 0, 0, 32'h0000_8001);
      issue(1, 32'h0000_1008, 32'h1000_0002, 32'h8001_1234, 2'b01, 3'b001, 5'd7, 1, 0, 0, 32'hFFFF_8001);
      issue(1, 32'h0000_100C, 32'h0000_0001, 32'h80AA_BBCC, 2'b01, 3'b100, 5'd8, 1, 0, 0, 32'h0000_00BB);
      issue(1, 32'h0000_1010, 32'h0000_0004, 32'h1234_567F, 2'b01, 3'b000, 5'd9, 1, 0, 0, 32'h0000_007F);
      issue(1, 32'h0000_1014, 32'h0000_0009, 32'h1234_F00D, 2'b01, 3'b001, 5'd10, 1, 0, 0, 32'hFFFF_F00D);
      issue(1, 32'h0000_1018, 32'h0000_0000, 32'hDEAD_BEEF, 2'b01, 3'b010, 5'd11, 1, 0, 0, 32'hDEAD_BEEF);
      issue(1, 32'h0000_101C, 32'h0000_0002, 32'hCAFE_F00D, 2'b01, 3'b011, 5'd12, 1, 0, 0, 32'hCAFE_F00D);
      issue(1, 32'h0000_1020, 32'h0000_0003, 32'h8000_00FF, 2'b01, 3'b110, 5'd13, 1, 0, 0, 32'h8000_00FF);
      // PC+4 and ALU selects
      issue(1, 32'hFFFF_FFFC, 32'h0000_0010, 32'h1111_1111, 2'b10, 3'b000, 5'd14, 1, 0, 0, 32'h0000_0000);
      issue(1, 32'h0000_0100, 32'h0000_0010, 32'h1111_1111, 2'b10, 3'b000, 5'd15, 1, 0, 0, 32'h0000_0104);
      issue(1, 32'h0000_0200, 32'h0000_ABCD, 32'h2222_2222, 2'b11, 3'b000, 5'd16, 1, 0, 0, 32'h0000_ABCD);
      // x0, no-write, bubble
      issue(1, 32'h0000_0204, 32'h0000_1234, 32'h3333_3333, 2'b00, 3'b000, 5'd0, 1, 0, 0, 32'h0000_1234);
      issue(1, 32'h0000_0208, 32'h0000_5678, 32'h3333_3333, 2'b00, 3'b000, 5'd9, 0, 0, 0, 32'h0000_5678);
      issue(0, 32'h0000_020C, 32'h0000_9999, 32'h3333_3333, 2'b00, 3'b000, 5'd9, 1, 0, 0, 32'h0000_9999);
      // stall hold: A then 3 stall cycles with changing inputs
      issue(1, 32'h0000_0300, 32'h0000_00AA, 32'h4444_4444, 2'b00, 3'b000, 5'd3, 1, 0, 0, 32'h0000_00AA);
      issue(1, 32'h0000_0304, 32'h0000_00BB, 32'h4444_4444, 2'b00, 3'b000, 5'd4, 1, 1, 0, 32'h0000_00BB);
      issue(1, 32'h0000_0308, 32'h0000_00CC, 32'h4444_4444, 2'b10, 3'b000, 5'd5, 1, 1, 0, 32'h0000_030C);
      issue(1, 32'h0000_030C, 32'h0000_00DD, 32'h4444_4444, 2'b01, 3'b010, 5'd6, 1, 1, 0, 32'h4444_4444);
      // flush beats stall
      issue(1, 32'h0000_0310, 32'h0000_00EE, 32'h4444_4444, 2'b00, 3'b000, 5'd7, 1, 1, 1, 32'h0000_00EE);
      issue(1, 32'h0000_0314, 32'h0000_00FF, 32'h4444_4444, 2'b00, 3'b000, 5'd8, 1, 1, 0, 32'h0000_00FF);
      issue(1, 32'h0000_0318, 32'h0000_0101, 32'h4444_4444, 2'b00, 3'b000, 5'd9, 1, 0, 0, 32'h0000_0101);
      // reset mid-stream, then resume
      issue(1, 32'h0000_0400, 32'h0000_0202, 32'h5555_5555, 2'b00, 3'b000, 5'd10, 1, 0, 0, 32'h0000_0202);
      do_reset();
      issue(1, 32'h0000_0404, 32'h0000_0303, 32'h5555_5555, 2'b00, 3'b000, 5'd11, 1, 0, 0, 32'h0000_0303);
      issue(1, 32'h0000_0408, 32'h0000_0404, 32'h5555_5555, 2'b00, 3'b000, 5'd12, 1, 0, 0, 32'h0000_0404);
      issue(0, 32'h0000_040C, 32'h0000_0505, 32'h5555_5555, 2'b00, 3'b000, 5'd13, 1, 0, 0, 32'h0000_0505);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
